// File: rtl/axi_ic_pkg.sv
// Shared types for the AXI interconnect read return path.
// The router that uses this package has an optional output register slice,
// enabled by defining R_OUTPUT_SLICE_EN.
package axi_ic_pkg;

    // AXI read response encodings
    typedef enum logic [1:0] {
        RRESP_OKAY   = 2'b00,
        RRESP_EXOKAY = 2'b01,
        RRESP_SLVERR = 2'b10,
        RRESP_DECERR = 2'b11
    } rresp_e;

    // Return-path router states: waiting for a slave, or locked to one burst
    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } r_state_e;

    // Default read-data width used by the interconnect
    localparam int unsigned R_DATA_W = 32;

    // One R beat at the default data width
    typedef struct packed {
        logic [R_DATA_W-1:0] data;
        rresp_e              resp;
        logic                last;
    } r_beat_t;

    // Index width for n items; never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The request just after ptr_i has top priority;
// the search wraps around, so the requester at ptr_i itself comes last.
module rr_arbiter
    import axi_ic_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    logic [31:0] idx;

    // Walk the requesters starting one past the pointer and keep the first hit
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = '0;
        for (int k = 1; k <= int'(N); k++) begin
            idx = (32'(ptr_i) + 32'(k)) % 32'(N);
            if (!grant_valid_o && req_i[idx[IDX_W-1:0]]) begin
                grant_valid_o            = 1'b1;
                grant_idx_o              = idx[IDX_W-1:0];
                grant_o[idx[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/read_data_channel_router.sv
// AXI read-data return router: arbitrates round-robin among slave ports with
// a valid beat, locks the grant for the whole burst (until the RLAST
// handshake) and steers beats to the master named by the RID latched at
// grant time. Beats whose RID names no existing master are accepted and
// dropped so the slave can finish its burst.
// Optional feature: define R_OUTPUT_SLICE_EN for a one-entry register slice
// on every master output (one extra cycle of latency, full throughput).
module read_data_channel_router
    import axi_ic_pkg::*;
#(
    parameter int unsigned Masters_Num   = 2,
    parameter int unsigned Num_Of_Slaves = 4,
    parameter int unsigned Master_ID_W   = clog2_min1(Masters_Num),
    parameter int unsigned Data_width    = 32,
    localparam int unsigned SEL_W        = clog2_min1(Num_Of_Slaves)
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [Data_width-1:0]    M_AXI_rdata  [Num_Of_Slaves],
    input  logic [1:0]               M_AXI_rresp  [Num_Of_Slaves],
    input  logic [Master_ID_W-1:0]   M_AXI_rid    [Num_Of_Slaves],
    input  logic [Num_Of_Slaves-1:0] M_AXI_rlast,
    input  logic [Num_Of_Slaves-1:0] M_AXI_rvalid,
    output logic [Num_Of_Slaves-1:0] M_AXI_rready,
    output logic [Data_width-1:0]    S_AXI_rdata  [Masters_Num],
    output logic [1:0]               S_AXI_rresp  [Masters_Num],
    output logic [Masters_Num-1:0]   S_AXI_rlast,
    output logic [Masters_Num-1:0]   S_AXI_rvalid,
    input  logic [Masters_Num-1:0]   S_AXI_rready,
    output logic                     R_Busy,
    output logic [SEL_W-1:0]         R_Selected_Slave
);

    r_state_e                 state_q, state_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [Num_Of_Slaves-1:0] sel_oh_q, sel_oh_d;
    logic [SEL_W-1:0]         ptr_q, ptr_d;
    logic [Master_ID_W-1:0]   rid_q, rid_d;

    logic [Num_Of_Slaves-1:0] arb_grant;
    logic [SEL_W-1:0]         arb_idx;
    logic                     arb_valid;

    // Current beat of the granted slave
    logic                     g_valid;
    logic                     g_last;
    logic [Data_width-1:0]    g_data;
    logic [1:0]               g_resp;

    logic [Masters_Num-1:0]   dest_oh;     // one-hot destination master, zero when sinking or idle
    logic                     dest_ready;  // destination can take the beat this cycle
    logic                     beat_ready;  // granted slave's beat is taken this cycle
    logic                     accept;      // beat handshake on the granted slave

    rr_arbiter #(
        .N     (Num_Of_Slaves),
        .IDX_W (SEL_W)
    ) u_rr_arbiter (
        .req_i         (M_AXI_rvalid),
        .ptr_i         (ptr_q),
        .grant_o       (arb_grant),
        .grant_idx_o   (arb_idx),
        .grant_valid_o (arb_valid)
    );

    assign g_valid = M_AXI_rvalid[sel_q];
    assign g_last  = M_AXI_rlast[sel_q];
    assign g_data  = M_AXI_rdata[sel_q];
    assign g_resp  = M_AXI_rresp[sel_q];

    // Decode the latched RID; an out-of-range RID decodes to no master at all
    genvar gi;
    generate
        for (gi = 0; gi < Masters_Num; gi++) begin : g_dest
            assign dest_oh[gi] = (state_q == R_BURST) && (rid_q == Master_ID_W'(gi));
        end
    endgenerate

`ifdef R_OUTPUT_SLICE_EN
    typedef struct packed {
        logic [Data_width-1:0] data;
        rresp_e                resp;
        logic                  last;
    } beat_t;

    logic [Masters_Num-1:0] slice_full;
    beat_t                  g_beat;

    assign g_beat     = '{data: g_data, resp: rresp_e'(g_resp), last: g_last};
    // A slice can take a new beat when empty or when it drains in the same cycle
    assign dest_ready = |(dest_oh & (~slice_full | S_AXI_rready));

    generate
        for (gi = 0; gi < Masters_Num; gi++) begin : g_slice
            logic  full_q;
            beat_t beat_q;
            logic  load;

            assign load = dest_oh[gi] & accept;

            // Capture a routed beat; empty once the master has taken it
            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    full_q <= 1'b0;
                    beat_q <= '0;
                end else if (load) begin
                    full_q <= 1'b1;
                    beat_q <= g_beat;
                end else if (S_AXI_rready[gi]) begin
                    full_q <= 1'b0;
                end
            end

            assign slice_full[gi]   = full_q;
            assign S_AXI_rvalid[gi] = full_q;
            assign S_AXI_rdata[gi]  = full_q ? beat_q.data : '0;
            assign S_AXI_rresp[gi]  = full_q ? beat_q.resp : 2'b00;
            assign S_AXI_rlast[gi]  = full_q & beat_q.last;
        end
    endgenerate
`else
    assign dest_ready = |(dest_oh & S_AXI_rready);

    generate
        for (gi = 0; gi < Masters_Num; gi++) begin : g_out
            assign S_AXI_rvalid[gi] = dest_oh[gi] & g_valid;
            assign S_AXI_rdata[gi]  = dest_oh[gi] ? g_data : '0;
            assign S_AXI_rresp[gi]  = dest_oh[gi] ? g_resp : 2'b00;
            assign S_AXI_rlast[gi]  = dest_oh[gi] & g_last;
        end
    endgenerate
`endif

    // Sunk bursts (no destination) are always accepted
    assign beat_ready = (dest_oh == '0) ? 1'b1 : dest_ready;
    assign accept     = (state_q == R_BURST) && g_valid && beat_ready;

    // State and grant registers; reset aborts any burst in flight
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= R_IDLE;
            sel_q    <= '0;
            sel_oh_q <= '0;
            ptr_q    <= SEL_W'(Num_Of_Slaves - 1);
            rid_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            sel_oh_q <= sel_oh_d;
            ptr_q    <= ptr_d;
            rid_q    <= rid_d;
        end
    end

    // Next state: grant in IDLE, release on the RLAST handshake
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        sel_oh_d = sel_oh_q;
        ptr_d    = ptr_q;
        rid_d    = rid_q;
        case (state_q)
            R_IDLE: begin
                if (arb_valid) begin
                    state_d  = R_BURST;
                    sel_d    = arb_idx;
                    sel_oh_d = arb_grant;
                    rid_d    = M_AXI_rid[arb_idx];
                end
            end
            R_BURST: begin
                if (accept && g_last) begin
                    state_d = R_IDLE;
                    ptr_d   = sel_q;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Outputs: only the granted slave sees rready, and only during a burst
    always_comb begin
        R_Busy           = (state_q == R_BURST);
        R_Selected_Slave = sel_q;
        M_AXI_rready     = ((state_q == R_BURST) && beat_ready) ? sel_oh_q : '0;
    end

endmodule

// File: tb/tb_read_data_channel_router.sv
// Randomised self-checking bench for read_data_channel_router.
// Slave-side stimulus comes from per-slave beat queues; the reference model
// replays the round-robin rule over those queues to predict the grant order
// and the beat stream each master must receive.
module tb_read_data_channel_router;

`ifdef R_OUTPUT_SLICE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [1:0]  rid;
        logic        last;
    } tb_beat_t;

    logic        ACLK    = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] M_rdata [4];
    logic [1:0]  M_rresp [4];
    logic [1:0]  M_rid   [4];
    logic [3:0]  M_rlast;
    logic [3:0]  M_rvalid;
    logic [3:0]  M_rready;
    logic [31:0] S_rdata [2];
    logic [1:0]  S_rresp [2];
    logic [1:0]  S_rlast;
    logic [1:0]  S_rvalid;
    logic [1:0]  S_rready;
    logic        busy;
    logic [1:0]  sel;

    always #5 ACLK = ~ACLK;

    read_data_channel_router #(
        .Masters_Num   (2),
        .Num_Of_Slaves (4),
        .Master_ID_W   (2),
        .Data_width    (32)
    ) dut (
        .ACLK             (ACLK),
        .ARESETN          (ARESETN),
        .M_AXI_rdata      (M_rdata),
        .M_AXI_rresp      (M_rresp),
        .M_AXI_rid        (M_rid),
        .M_AXI_rlast      (M_rlast),
        .M_AXI_rvalid     (M_rvalid),
        .M_AXI_rready     (M_rready),
        .S_AXI_rdata      (S_rdata),
        .S_AXI_rresp      (S_rresp),
        .S_AXI_rlast      (S_rlast),
        .S_AXI_rvalid     (S_rvalid),
        .S_AXI_rready     (S_rready),
        .R_Busy           (busy),
        .R_Selected_Slave (sel)
    );

    tb_beat_t   sq    [4][$];
    tb_beat_t   obs   [2][$];
    tb_beat_t   exp_q [2][$];
    int         order_exp[$];
    logic [2:0] log_q[$];
    bit         mid     [4];
    bit         hs_pend [4];
    int         rready_mode;
    bit         gap_en;
    int         s_valid_seen;
    int         total_hs;
    int         sunk_exp;
    int         ptr_model;
    int         compared   = 0;
    int         mismatched = 0;

    task automatic drive();
        for (int s = 0; s < 4; s++) begin
            if (sq[s].size() > 0) begin
                M_rdata[s]  = sq[s][0].data;
                M_rresp[s]  = sq[s][0].resp;
                M_rid[s]    = sq[s][0].rid;
                M_rlast[s]  = sq[s][0].last;
                M_rvalid[s] = !(mid[s] && gap_en && ($urandom_range(0, 2) == 0));
            end else begin
                M_rdata[s]  = '0;
                M_rresp[s]  = '0;
                M_rid[s]    = '0;
                M_rlast[s]  = 1'b0;
                M_rvalid[s] = 1'b0;
            end
        end
        case (rready_mode)
            0:       S_rready = 2'b11;
            1:       S_rready = 2'($urandom_range(0, 3));
            default: S_rready = ~S_rready;
        endcase
    endtask

    task automatic sample();
        tb_beat_t b;
        for (int m = 0; m < 2; m++) begin
            if (S_rvalid[m]) s_valid_seen++;
            if (S_rvalid[m] && S_rready[m]) begin
                b = '{data: S_rdata[m], resp: S_rresp[m], rid: 2'(m), last: S_rlast[m]};
                obs[m].push_back(b);
                $display("[%0t] beat to master %0d data=%h resp=%0d last=%0b",
                         $time, m, b.data, b.resp, b.last);
            end
        end
        for (int s = 0; s < 4; s++) begin
            hs_pend[s] = M_rvalid[s] && M_rready[s];
            if (hs_pend[s]) total_hs++;
        end
        log_q.push_back({busy, sel});
    endtask

    // One clock: retire accepted beats, drive the next ones, sample mid-cycle
    task automatic step();
        @(posedge ACLK);
        #1;
        for (int s = 0; s < 4; s++) begin
            if (hs_pend[s]) begin
                mid[s] = !sq[s][0].last;
                void'(sq[s].pop_front());
                hs_pend[s] = 1'b0;
            end
        end
        drive();
        @(negedge ACLK);
        sample();
    endtask

    task automatic clear_all();
        for (int s = 0; s < 4; s++) begin
            sq[s].delete();
            mid[s]     = 1'b0;
            hs_pend[s] = 1'b0;
        end
        for (int m = 0; m < 2; m++) begin
            obs[m].delete();
            exp_q[m].delete();
        end
        order_exp.delete();
        log_q.delete();
        s_valid_seen = 0;
        total_hs     = 0;
        sunk_exp     = 0;
    endtask

    task automatic do_reset();
        clear_all();
        rready_mode = 0;
        gap_en      = 1'b0;
        ARESETN     = 1'b0;
        drive();
        repeat (2) @(negedge ACLK);
        ARESETN   = 1'b1;
        ptr_model = 3;
    endtask

    task automatic add_burst(input int s, input int len, input logic [1:0] rid);
        tb_beat_t b;
        for (int i = 0; i < len; i++) begin
            b = '{data: $urandom, resp: 2'($urandom_range(0, 3)), rid: rid, last: (i == len - 1)};
            sq[s].push_back(b);
        end
    endtask

    // Reference: every slave holding bursts requests whenever the router is
    // idle; the winner is the first such slave after the last one served.
    task automatic build_model();
        tb_beat_t cp[4][$];
        tb_beat_t b;
        int       found;
        int       s;
        for (int i = 0; i < 4; i++) cp[i] = sq[i];
        found = 0;
        while (found >= 0) begin
            found = -1;
            for (int k = 1; k <= 4; k++) begin
                s = (ptr_model + k) % 4;
                if (found < 0 && cp[s].size() > 0) found = s;
            end
            if (found >= 0) begin
                order_exp.push_back(found);
                do begin
                    b = cp[found].pop_front();
                    if (int'(b.rid) < 2) exp_q[int'(b.rid)].push_back(b);
                    else sunk_exp++;
                end while (!b.last);
                ptr_model = found;
            end
        end
    endtask

    function automatic int stream_errors();
        int e = 0;
        for (int m = 0; m < 2; m++) begin
            if (obs[m].size() != exp_q[m].size()) e++;
            else
                for (int i = 0; i < obs[m].size(); i++)
                    if (obs[m][i].data !== exp_q[m][i].data || obs[m][i].resp !== exp_q[m][i].resp ||
                        obs[m][i].last !== exp_q[m][i].last) e++;
        end
        return e;
    endfunction

    task automatic run_drain(input string name);
        int n = 0;
        while ((sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size()) > 0 && n < 3000) begin
            step();
            n++;
        end
        repeat (6) step();
        compared++;
        if ((sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size()) != 0) begin
            mismatched++;
            $display("FAIL %s_drain: beats still queued after %0d cycles, required none", name, n);
        end
    endtask

    task automatic test_reset();
        ARESETN  = 1'b0;
        M_rvalid = 4'hF;
        M_rlast  = 4'hF;
        S_rready = 2'b11;
        repeat (2) @(negedge ACLK);
        compared++;
        if (S_rvalid !== 2'b00 || M_rready !== 4'h0 || busy !== 1'b0 || sel !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_ctrl: S_rvalid=%b M_rready=%b busy=%b sel=%0d, required all 0",
                     S_rvalid, M_rready, busy, sel);
        end
        compared++;
        if (S_rdata[0] !== 32'h0 || S_rdata[1] !== 32'h0 || S_rresp[0] !== 2'b00 ||
            S_rresp[1] !== 2'b00 || S_rlast !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_data: data0=%h data1=%h rlast=%b, required 0",
                     S_rdata[0], S_rdata[1], S_rlast);
        end
        do_reset();
    endtask

    task automatic test_single_beat();
        tb_beat_t b;
        do_reset();
        b = '{data: 32'hA5A5A5A5, resp: 2'b00, rid: 2'd1, last: 1'b1};
        sq[1].push_back(b);
        build_model();
        for (int k = 0; k <= LAT; k++) begin
            step();
            compared++;
            if (S_rvalid !== ((k == LAT) ? 2'b10 : 2'b00)) begin
                mismatched++;
                $display("FAIL single_rvalid cycle %0d: got %b, required %b",
                         k, S_rvalid, (k == LAT) ? 2'b10 : 2'b00);
            end
            if (k == 1) begin
                compared++;
                if (busy !== 1'b1 || sel !== 2'd1) begin
                    mismatched++;
                    $display("FAIL single_grant: busy=%b sel=%0d, required busy=1 sel=1", busy, sel);
                end
            end
            if (k == LAT) begin
                compared++;
                if (S_rdata[1] !== 32'hA5A5A5A5 || S_rlast !== 2'b10 || S_rdata[0] !== 32'h0) begin
                    mismatched++;
                    $display("FAIL single_data: data1=%h data0=%h rlast=%b, required a5a5a5a5/0/10",
                             S_rdata[1], S_rdata[0], S_rlast);
                end
            end
        end
        run_drain("single");
        compared++;
        if (stream_errors() !== 0) begin
            mismatched++;
            $display("FAIL single_stream: %0d beat errors, required 0", stream_errors());
        end
    endtask

    task automatic test_burst_toggle();
        do_reset();
        S_rready    = 2'b00;
        rready_mode = 2;
        add_burst(0, 4, 2'd0);
        build_model();
        run_drain("toggle");
        compared++;
        if (obs[0].size() !== 4 || obs[1].size() !== 0) begin
            mismatched++;
            $display("FAIL toggle_count: S00 %0d S01 %0d beats, required 4 and 0",
                     obs[0].size(), obs[1].size());
        end
        compared++;
        if (stream_errors() !== 0) begin
            mismatched++;
            $display("FAIL toggle_stream: %0d beat errors, required 0", stream_errors());
        end
    endtask

    task automatic test_rotation();
        int         rises[$];
        int         gaps_bad = 0;
        int         sel_bad  = 0;
        int         zrun     = 0;
        bit         seen_one = 1'b0;
        int         cur      = -1;
        logic [2:0] e;
        do_reset();
        for (int s = 0; s < 4; s++) add_burst(s, 2, 2'($urandom_range(0, 1)));
        build_model();
        run_drain("rotation");
        for (int i = 0; i < log_q.size(); i++) begin
            e = log_q[i];
            if (e[2]) begin
                if (i == 0 || !log_q[i-1][2]) begin
                    rises.push_back(int'(e[1:0]));
                    if (seen_one && zrun != 1) gaps_bad++;
                    cur = int'(e[1:0]);
                end else if (int'(e[1:0]) != cur) begin
                    sel_bad++;
                end
                seen_one = 1'b1;
                zrun     = 0;
            end else begin
                zrun++;
            end
        end
        compared++;
        if (rises.size() !== order_exp.size()) begin
            mismatched++;
            $display("FAIL rotation_bursts: %0d grants, required %0d", rises.size(), order_exp.size());
        end else begin
            for (int i = 0; i < rises.size(); i++) begin
                compared++;
                if (rises[i] !== order_exp[i]) begin
                    mismatched++;
                    $display("FAIL rotation_order %0d: slave %0d, required %0d", i, rises[i], order_exp[i]);
                end
            end
        end
        compared++;
        if (gaps_bad !== 0 || sel_bad !== 0) begin
            mismatched++;
            $display("FAIL rotation_timing: %0d bad idle gaps, %0d select changes, required 0 and 0",
                     gaps_bad, sel_bad);
        end
        compared++;
        if (stream_errors() !== 0) begin
            mismatched++;
            $display("FAIL rotation_stream: %0d beat errors, required 0", stream_errors());
        end
    endtask

    task automatic test_sink();
        do_reset();
        add_burst(2, 3, 2'd3);
        build_model();
        run_drain("sink");
        compared++;
        if (s_valid_seen !== 0 || total_hs !== 3 || total_hs !== sunk_exp) begin
            mismatched++;
            $display("FAIL sink: S rvalid cycles %0d, slave handshakes %0d, required 0 and %0d",
                     s_valid_seen, total_hs, sunk_exp);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL sink_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n     = 0;
        int first = -1;
        do_reset();
        add_burst(2, 4, 2'd0);
        while (total_hs < 1 && n < 20) begin
            step();
            n++;
        end
        step();
        ARESETN = 1'b0;
        #1;
        compared++;
        if (S_rvalid !== 2'b00 || M_rready !== 4'h0 || busy !== 1'b0 || sel !== 2'd0 ||
            S_rdata[0] !== 32'h0 || total_hs < 1) begin
            mismatched++;
            $display("FAIL midreset_outputs: S_rvalid=%b M_rready=%b busy=%b sel=%0d data0=%h hs=%0d, required zeros and hs>=1",
                     S_rvalid, M_rready, busy, sel, S_rdata[0], total_hs);
        end
        clear_all();
        drive();
        repeat (2) @(negedge ACLK);
        ARESETN   = 1'b1;
        ptr_model = 3;
        add_burst(3, 1, 2'd1);
        add_burst(0, 1, 2'd0);
        build_model();
        run_drain("midreset");
        for (int i = log_q.size() - 1; i >= 0; i--)
            if (log_q[i][2]) first = int'(log_q[i][1:0]);
        compared++;
        if (first !== 0) begin
            mismatched++;
            $display("FAIL midreset_first_grant: slave %0d, required 0", first);
        end
        compared++;
        if (stream_errors() !== 0) begin
            mismatched++;
            $display("FAIL midreset_stream: %0d beat errors, required 0", stream_errors());
        end
    endtask

    task automatic test_back_to_back();
        tb_beat_t bb[4];
        bit       ev;
        do_reset();
        add_burst(0, 4, 2'd0);
        for (int i = 0; i < 4; i++) bb[i] = sq[0][i];
        for (int k = 0; k <= LAT + 4; k++) begin
            step();
            ev = (k >= LAT) && (k < LAT + 4);
            compared++;
            if (S_rvalid !== {1'b0, ev}) begin
                mismatched++;
                $display("FAIL b2b_rvalid cycle %0d: got %b, required %b", k, S_rvalid, {1'b0, ev});
            end
            if (ev) begin
                compared++;
                if (S_rdata[0] !== bb[k-LAT].data) begin
                    mismatched++;
                    $display("FAIL b2b_data cycle %0d: got %h, required %h", k, S_rdata[0], bb[k-LAT].data);
                end
            end
        end
        run_drain("b2b");
    endtask

    task automatic test_random();
        int errs;
        do_reset();
        for (int r = 0; r < 20; r++) begin
            clear_all();
            rready_mode = 1;
            gap_en      = 1'b1;
            for (int s = 0; s < 4; s++)
                for (int b = $urandom_range(0, 2); b > 0; b--)
                    add_burst(s, $urandom_range(1, 4), 2'($urandom_range(0, 3)));
            build_model();
            run_drain("random");
            errs = stream_errors();
            compared++;
            if (errs !== 0) begin
                mismatched++;
                $display("FAIL random_stream round %0d: %0d beat errors, required 0", r, errs);
            end
            compared++;
            if (total_hs !== exp_q[0].size() + exp_q[1].size() + sunk_exp) begin
                mismatched++;
                $display("FAIL random_handshakes round %0d: got %0d, required %0d",
                         r, total_hs, exp_q[0].size() + exp_q[1].size() + sunk_exp);
            end
        end
    endtask

    initial begin
        rready_mode = 0;
        gap_en      = 1'b0;
        ptr_model   = 3;
        clear_all();
        drive();
        test_reset();
        test_single_beat();
        test_burst_toggle();
        test_rotation();
        test_sink();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
